csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 218 +++++++++++++++++++++
 tb/tb_csr_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// -----------------------------------------------------------------------------
// csr_unit -- machine-mode CSR file for a single-hart RISC-V core.
//
// Implements mstatus (MIE/MPIE writable, MPP fixed at 2'b11), mtvec,
// mscratch, mepc, mcause and a read-only mhartid. It also handles the
// ecall/ebreak trap entry and the mret return.
//
// Optional feature: define CSR_COUNTERS_EN to add the 64-bit mcycle and
// minstret counters. For XLEN=32 the high halves sit at 0xB80/0xB82.
//
// Parameters:
//   XLEN     CSR data width (32 or 64)
//   HART_ID  value returned by mhartid
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   csr_op     00 none, 01 write, 10 set, 11 clear
//   addr       CSR address (fully decoded)
//   wdata      operand for write/set/clear
//   is_ecall, is_ebreak, is_mret, instret
//              retire-stage events
//   pc         PC of the trapping instruction
//   rdata      combinational read of addr (value before the update)
//   illegal    addr unmapped, or a nonzero op to a read-only address
//   mtvec_out  trap target, 4-byte aligned
//   mepc_out   return target
// -----------------------------------------------------------------------------
module csr_unit #(
    parameter int XLEN    = 32,
    parameter int HART_ID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_mret,
    input  logic            instret,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] rdata,
    output logic            illegal,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out
);

    // Architectural state. mstatus is stored only as its two live bits.
    logic            mie_q,      mie_d;
    logic            mpie_q,     mpie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;

`ifdef CSR_COUNTERS_EN
    logic [63:0]     mcycle_q,   mcycle_d;
    logic [63:0]     minstret_q, minstret_d;
`else
    logic            unused_instret_s;
    assign unused_instret_s = instret;
`endif

    logic [XLEN-1:0] mstatus_s;
    logic [XLEN-1:0] new_val_s;
    logic            mapped_s;
    logic            read_only_s;

    // mstatus view: MPP=11 at bits 12:11, MPIE at bit 7, MIE at bit 3.
    assign mstatus_s = XLEN'({2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

    assign mtvec_out = {mtvec_q[XLEN-1:2], 2'b00};
    assign mepc_out  = mepc_q;

    // Read mux and address decode (mapped / read-only classification).
    always_comb begin
        rdata       = {XLEN{1'b0}};
        mapped_s    = 1'b1;
        read_only_s = 1'b0;
        case (addr)
            12'h300: rdata = mstatus_s;
            12'h305: rdata = mtvec_q;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'hF14: begin
                rdata       = XLEN'(HART_ID);
                read_only_s = 1'b1;
            end
`ifdef CSR_COUNTERS_EN
            12'hB00: rdata = mcycle_q[XLEN-1:0];
            12'hB02: rdata = minstret_q[XLEN-1:0];
            // High halves only exist when the register is narrower than 64 bits.
            12'hB80: begin
                if (XLEN == 32) begin
                    rdata = XLEN'(mcycle_q[63:32]);
                end else begin
                    mapped_s = 1'b0;
                end
            end
            12'hB82: begin
                if (XLEN == 32) begin
                    rdata = XLEN'(minstret_q[63:32]);
                end else begin
                    mapped_s = 1'b0;
                end
            end
`endif
            default: mapped_s = 1'b0;
        endcase
    end

    assign illegal = ~mapped_s | ((csr_op != 2'b00) & read_only_s);

    // Read-modify-write operand, built from the value before the update.
    always_comb begin
        case (csr_op)
            2'b01:   new_val_s = wdata;
            2'b10:   new_val_s = rdata | wdata;
            2'b11:   new_val_s = rdata & ~wdata;
            default: new_val_s = rdata;
        endcase
    end

    // Next-state logic. Priority is ecall > ebreak > mret > csr_op; the
    // winner takes the whole cycle and every lower-priority request is dropped.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = instret ? (minstret_q + 64'd1) : minstret_q;
`endif
        if (is_ecall) begin
            mepc_d   = pc & ~XLEN'(2'b11);
            mcause_d = XLEN'(4'd11);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (is_ebreak) begin
            mepc_d   = pc & ~XLEN'(2'b11);
            mcause_d = XLEN'(4'd3);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (is_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if ((csr_op != 2'b00) && !illegal) begin
            case (addr)
                12'h300: begin
                    mie_d  = new_val_s[3];
                    mpie_d = new_val_s[7];
                end
                12'h305: mtvec_d    = new_val_s;
                12'h340: mscratch_d = new_val_s;
                12'h341: mepc_d     = new_val_s & ~XLEN'(2'b11);
                12'h342: mcause_d   = new_val_s;
`ifdef CSR_COUNTERS_EN
                // A written half replaces the stored half and freezes the
                // rest of the counter for this cycle.
                12'hB00: begin
                    mcycle_d             = mcycle_q;
                    mcycle_d[XLEN-1:0]   = new_val_s;
                end
                12'hB02: begin
                    minstret_d           = minstret_q;
                    minstret_d[XLEN-1:0] = new_val_s;
                end
                12'hB80: begin
                    mcycle_d             = mcycle_q;
                    mcycle_d[63:32]      = new_val_s[31:0];
                end
                12'hB82: begin
                    minstret_d           = minstret_q;
                    minstret_d[63:32]    = new_val_s[31:0];
                end
`endif
                default: begin
                    // mhartid and unmapped addresses never reach this point.
                end
            endcase
        end else begin
            // Idle cycle or illegal access: all CSRs hold.
        end
    end

    // CSR state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {XLEN{1'b0}};
            mscratch_q <= {XLEN{1'b0}};
            mepc_q     <= {XLEN{1'b0}};
            mcause_q   <= {XLEN{1'b0}};
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
`endif
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_unit -- scoreboard testbench for csr_unit (XLEN=32, HART_ID=7).
// The stimulus queues hand-computed expectations tagged with the cycle they
// apply to. The monitor pops and compares them on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_csr_unit;

    localparam int XLEN  = 32;
    localparam int HART  = 7;
    localparam int S_RD  = 0;
    localparam int S_ILL = 1;
    localparam int S_TV  = 2;
    localparam int S_EPC = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      csr_op = 2'b00;
    logic [11:0]     addr = 12'h000;
    logic [XLEN-1:0] wdata = 32'h0;
    logic            is_ecall = 1'b0, is_ebreak = 1'b0, is_mret = 1'b0, instret = 1'b0;
    logic [XLEN-1:0] pc = 32'h0;
    logic [XLEN-1:0] rdata, mtvec_out, mepc_out;
    logic            illegal;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(XLEN), .HART_ID(HART)) dut (
        .clk(clk), .rst(rst), .csr_op(csr_op), .addr(addr), .wdata(wdata),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
        .instret(instret), .pc(pc), .rdata(rdata), .illegal(illegal),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_RD:    return rdata;
            S_ILL:   return {31'd0, illegal};
            S_TV:    return mtvec_out;
            default: return mepc_out;
        endcase
    endfunction

    task automatic expect_now(input int sel, input logic [31:0] e, input string n);
        exp_t x;
        x.due  = cyc;
        x.sel  = sel;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t        x;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x   = sb.pop_front();
            act = pick(x.sel);
            total++;
            if (x.due != cyc || act !== x.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h (cycle %0d due %0d)",
                         x.name, act, x.exp, cyc, x.due);
            end
        end
    end

    // Wait for the next rising edge, then drive one cycle of inputs.
    // ev = {ecall, ebreak, mret, instret}
    task automatic cyc_in(input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] wd, input logic [3:0] ev,
                          input logic [31:0] p);
        @(posedge clk);
        #1;
        csr_op    = op;
        addr      = a;
        wdata     = wd;
        is_ecall  = ev[3];
        is_ebreak = ev[2];
        is_mret   = ev[1];
        instret   = ev[0];
        pc        = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Values while reset is held low.
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD,  32'h0000_1800, "reset_mstatus");
        expect_now(S_TV,  32'h0,         "reset_mtvec_out");
        expect_now(S_EPC, 32'h0,         "reset_mepc_out");
        expect_now(S_ILL, 32'h0,         "reset_illegal");
        rst = 1'b1;

        cyc_in(2'b01, 12'h340, 32'h0000_0055, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0, "mscratch_pre");

        // Reset asserted in the middle of an mtvec write.
        cyc_in(2'b01, 12'h305, 32'h8000_0103, 4'b0000, 32'h0);
        #2 rst = 1'b0;
        expect_now(S_TV, 32'h0, "midop_mtvec_out");
        expect_now(S_RD, 32'h0, "midop_rdata");
        @(posedge clk);
        #1 rst = 1'b1;
        expect_now(S_TV, 32'h0, "midop_hold");

        // The same op is still driven after release, so it commits here.
        cyc_in(2'b00, 12'h305, 32'h0, 4'b0000, 32'h0);
        expect_now(S_TV, 32'h8000_0100, "mtvec_out_aligned");
        expect_now(S_RD, 32'h8000_0103, "mtvec_raw");
        cyc_in(2'b00, 12'h340, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0, "mscratch_reset_cleared");

        // mstatus: only MIE and MPIE are writable.
        cyc_in(2'b01, 12'h300, 32'h0000_0008, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0000_1800, "mstatus_old");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0000_1808, "mstatus_mie");

        // ecall trap entry.
        cyc_in(2'b00, 12'h300, 32'h0, 4'b1000, 32'h8000_0010);
        expect_now(S_RD, 32'h0000_1808, "ecall_preupdate");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_EPC, 32'h8000_0010, "ecall_mepc");
        expect_now(S_RD,  32'h0000_1880, "ecall_mstatus");
        cyc_in(2'b00, 12'h342, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0000_000B, "ecall_mcause");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0010, 32'h0);
        expect_now(S_RD, 32'h0000_1880, "mret_preupdate");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0000_1888, "mret_mstatus");

        // mscratch write, then set, then clear.
        cyc_in(2'b01, 12'h340, 32'hF0F0_F0F0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0, "mscratch_w_old");
        cyc_in(2'b10, 12'h340, 32'h0000_000F, 4'b0000, 32'h0);
        expect_now(S_RD, 32'hF0F0_F0F0, "mscratch_set_old");
        cyc_in(2'b11, 12'h340, 32'hF000_0000, 4'b0000, 32'h0);
        expect_now(S_RD, 32'hF0F0_F0FF, "mscratch_clr_old");
        cyc_in(2'b00, 12'h340, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h00F0_F0FF, "mscratch_final");

        // Illegal accesses.
        cyc_in(2'b01, 12'hF14, 32'h0000_0055, 4'b0000, 32'h0);
        expect_now(S_ILL, 32'h1, "hartid_write_illegal");
        expect_now(S_RD,  32'h7, "hartid_rdata");
        cyc_in(2'b00, 12'hF14, 32'h0, 4'b0000, 32'h0);
        expect_now(S_ILL, 32'h0, "hartid_read_legal");
        expect_now(S_RD,  32'h7, "hartid_unchanged");
        cyc_in(2'b01, 12'h7C0, 32'h0000_0123, 4'b0000, 32'h0);
        expect_now(S_ILL, 32'h1, "unmapped_write_illegal");
        expect_now(S_RD,  32'h0, "unmapped_rdata");
        cyc_in(2'b00, 12'h7C0, 32'h0, 4'b0000, 32'h0);
        expect_now(S_ILL, 32'h1, "unmapped_read_illegal");
        expect_now(S_TV,  32'h8000_0100, "illegal_no_change_tv");
        expect_now(S_EPC, 32'h8000_0010, "illegal_no_change_epc");

        // ecall, mret and an mepc write in the same cycle: only ecall acts.
        cyc_in(2'b01, 12'h341, 32'h0000_1234, 4'b1010, 32'h4000_0006);
        expect_now(S_RD, 32'h8000_0010, "prio_old_mepc");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_EPC, 32'h4000_0004, "prio_mepc_pc");
        expect_now(S_RD,  32'h0000_1880, "prio_mstatus");

        // ebreak with mret also asserted.
        cyc_in(2'b00, 12'h342, 32'h0, 4'b0110, 32'h0000_0100);
        expect_now(S_RD, 32'h0000_000B, "ebreak_pre_mcause");
        cyc_in(2'b00, 12'h342, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD,  32'h0000_0003, "ebreak_mcause");
        expect_now(S_EPC, 32'h0000_0100, "ebreak_mepc");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0000_1800, "ebreak_mstatus");

        // Low bits of mepc are forced to zero; mstatus ignores unwritable bits.
        cyc_in(2'b01, 12'h341, 32'h0000_1237, 4'b0000, 32'h0);
        cyc_in(2'b01, 12'h300, 32'hFFFF_FFFF, 4'b0000, 32'h0);
        expect_now(S_EPC, 32'h0000_1234, "mepc_write_aligned");
        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0000_1888, "mstatus_all_ones");

`ifdef CSR_COUNTERS_EN
        cyc_in(2'b01, 12'hB00, 32'hFFFF_FFFF, 4'b0000, 32'h0);
        cyc_in(2'b01, 12'hB80, 32'hFFFF_FFFF, 4'b0000, 32'h0);
        cyc_in(2'b00, 12'hB00, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'hFFFF_FFFF, "mcycle_lo_written");
        cyc_in(2'b00, 12'hB80, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h0, "mcycle_hi_wrapped");
        cyc_in(2'b00, 12'hB00, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h1, "mcycle_lo_one");
        cyc_in(2'b01, 12'hB02, 32'h0000_0005, 4'b0000, 32'h0);
        cyc_in(2'b00, 12'hB02, 32'h0, 4'b0001, 32'h0);
        expect_now(S_RD, 32'h5, "minstret_written");
        cyc_in(2'b00, 12'hB02, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h6, "minstret_incr");
        cyc_in(2'b00, 12'hB02, 32'h0, 4'b0000, 32'h0);
        expect_now(S_RD, 32'h6, "minstret_hold");
`else
        cyc_in(2'b01, 12'hB00, 32'h0000_0001, 4'b0000, 32'h0);
        expect_now(S_ILL, 32'h1, "mcycle_absent_illegal");
        expect_now(S_RD,  32'h0, "mcycle_absent_rdata");
        cyc_in(2'b00, 12'hB82, 32'h0, 4'b0000, 32'h0);
        expect_now(S_ILL, 32'h1, "minstreth_absent_illegal");
`endif

        cyc_in(2'b00, 12'h300, 32'h0, 4'b0000, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
